// File: rtl/key_press_decoder.sv
// Gesture classifier fed by a key debounce filter: turns press/release flags into
// single-click, double-click, long-press and auto-repeat one-cycle events.
module key_press_decoder #(
    parameter int LONG_CYC    = 50_000_000,
    parameter int DBL_GAP_CYC = 12_500_000,
    parameter int REPEAT_CYC  = 10_000_000,
    parameter int CNT_W       = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic key_flag,
    input  logic key_state,
    output logic single_pulse,
    output logic double_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic key_held,
    output logic busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRESS1 = 3'd1,
        S_WAIT2  = 3'd2,
        S_PRESS2 = 3'd3,
        S_LONG   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] DBL_TERM  = CNT_W'(DBL_GAP_CYC - 1);
    localparam logic [CNT_W-1:0] REP_TERM  = CNT_W'(REPEAT_CYC - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             single_q;
    logic             double_q;
    logic             long_q;
    logic             repeat_q;
    logic             held_q;
    logic             busy_q;

    logic press_ev;
    logic rel_ev;

    // Flags whose level matches what the current state already tracks fall through unused.
    assign press_ev = key_flag & ~key_state;
    assign rel_ev   = key_flag & key_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            single_q <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            held_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            single_q <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (press_ev) begin
                        state_q <= S_PRESS1;
                        cnt_q   <= '0;
                        held_q  <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_PRESS1: begin
                    // A release on the threshold cycle still counts as a short press.
                    if (rel_ev) begin
                        state_q <= S_WAIT2;
                        cnt_q   <= '0;
                        held_q  <= 1'b0;
                    end else if (cnt_q == LONG_TERM) begin
                        state_q <= S_LONG;
                        cnt_q   <= '0;
                        long_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_WAIT2: begin
                    if (press_ev) begin
                        state_q <= S_PRESS2;
                        cnt_q   <= '0;
                        held_q  <= 1'b1;
                    end else if (cnt_q == DBL_TERM) begin
                        state_q  <= S_IDLE;
                        cnt_q    <= '0;
                        single_q <= 1'b1;
                        busy_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_PRESS2: begin
                    if (rel_ev) begin
                        state_q  <= S_IDLE;
                        cnt_q    <= '0;
                        double_q <= 1'b1;
                        held_q   <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                end
                S_LONG: begin
                    if (rel_ev) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        held_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == REP_TERM) begin
                        cnt_q    <= '0;
                        repeat_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    held_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign single_pulse = single_q;
    assign double_pulse = double_q;
    assign long_pulse   = long_q;
    assign repeat_pulse = repeat_q;
    assign key_held     = held_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_key_press_decoder.sv
// Randomized gesture bench: expected events are derived from gesture timing and
// queued; a negedge monitor pops and compares every pulse plus busy/key_held.
module tb_key_press_decoder;

    localparam int LONG_CYC    = 20;
    localparam int DBL_GAP_CYC = 8;
    localparam int REPEAT_CYC  = 5;
    localparam int CNT_W       = 8;
    localparam int MAXC        = 40000;

    localparam int K_SGL  = 0;
    localparam int K_DBL  = 1;
    localparam int K_LONG = 2;
    localparam int K_REP  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_flag = 1'b0;
    logic key_state = 1'b1;
    logic single_pulse;
    logic double_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic key_held;
    logic busy;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    bit  exp_busy [MAXC];
    bit  exp_held [MAXC];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    int  npulse;
    int  got_kind;
    ev_t ev;
    bit  final_check = 1'b0;
    bit  final_done = 1'b0;

    key_press_decoder #(
        .LONG_CYC   (LONG_CYC),
        .DBL_GAP_CYC(DBL_GAP_CYC),
        .REPEAT_CYC (REPEAT_CYC),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_flag    (key_flag),
        .key_state   (key_state),
        .single_pulse(single_pulse),
        .double_pulse(double_pulse),
        .long_pulse  (long_pulse),
        .repeat_pulse(repeat_pulse),
        .key_held    (key_held),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: one line per observed pulse, status compared every cycle.
    always @(negedge clk) begin
        if (cyc >= 1 && cyc < MAXC) begin
            checks += 2;
            if (busy !== exp_busy[cyc]) begin
                errors++;
                $display("FAIL busy @%0d: got %b want %b", cyc, busy, exp_busy[cyc]);
            end
            if (key_held !== exp_held[cyc]) begin
                errors++;
                $display("FAIL key_held @%0d: got %b want %b", cyc, key_held, exp_held[cyc]);
            end
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_event: kind %0d expected @%0d, not observed by %0d",
                         exp_q[0].kind, exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end
            npulse = $countones({single_pulse, double_pulse, long_pulse, repeat_pulse});
            if (npulse > 1) begin
                checks++;
                errors++;
                $display("FAIL multi_pulse @%0d: got %0d pulses want 1", cyc, npulse);
            end
            if (npulse >= 1) begin
                got_kind = single_pulse ? K_SGL : double_pulse ? K_DBL :
                           long_pulse ? K_LONG : K_REP;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse @%0d: got kind %0d want none", cyc, got_kind);
                end else begin
                    ev = exp_q.pop_front();
                    if (ev.kind != got_kind || ev.cyc != cyc) begin
                        errors++;
                        $display("FAIL event: got kind %0d @%0d want kind %0d @%0d",
                                 got_kind, cyc, ev.kind, ev.cyc);
                    end else begin
                        $display("event kind %0d @%0d ok", got_kind, cyc);
                    end
                end
            end
        end
        if (final_check && !final_done) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL leftover_events: got %0d pending want 0", exp_q.size());
            end
            final_done = 1'b1;
        end
    end

    task automatic step(input logic f, input logic level);
        @(posedge clk);
        #1;
        key_flag  = f;
        key_state = level;
    endtask

    task automatic hold(input int n, input logic level, input bit spur);
        for (int i = 0; i < n; i++)
            step(spur && ($urandom_range(0, 7) == 0), level);
    endtask

    task automatic push(input int k, input int c);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic mark_busy(input int a, input int b);
        for (int c = a; c <= b; c++) exp_busy[c] = 1'b1;
    endtask

    task automatic mark_held(input int a, input int b);
        for (int c = a; c <= b; c++) exp_held[c] = 1'b1;
    endtask

    // One gesture: press held h1 cycles; for a double, gap g then second press held h2.
    task automatic gesture(input int h1, input int g, input int h2, input bit dbl, input bit spur);
        int t;
        int r;
        int r2;
        int end_c;
        bit is_dbl;
        step(1'b1, 1'b0);
        t = cyc;
        r = t + h1;
        is_dbl = dbl && (h1 <= LONG_CYC);
        if (h1 > LONG_CYC) begin
            push(K_LONG, t + LONG_CYC + 1);
            for (int c = t + LONG_CYC + 1 + REPEAT_CYC; c <= r; c += REPEAT_CYC)
                push(K_REP, c);
            end_c = r + 1;
            mark_held(t + 1, r);
        end else if (is_dbl) begin
            r2 = r + g + h2;
            push(K_DBL, r2 + 1);
            end_c = r2 + 1;
            mark_held(t + 1, r);
            mark_held(r + g + 1, r2);
        end else begin
            end_c = r + DBL_GAP_CYC + 1;
            push(K_SGL, end_c);
            mark_held(t + 1, r);
        end
        mark_busy(t + 1, end_c - 1);
        hold(h1 - 1, 1'b0, spur);
        step(1'b1, 1'b1);
        if (is_dbl) begin
            hold(g - 1, 1'b1, spur);
            step(1'b1, 1'b0);
            hold(h2 - 1, 1'b0, spur);
            step(1'b1, 1'b1);
        end
        while (cyc < end_c) step(spur && ($urandom_range(0, 7) == 0), 1'b1);
        hold($urandom_range(0, 5), 1'b1, spur);
    endtask

    initial begin
        int t;
        int kind;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle, then a release flag while idle must do nothing.
        hold(100, 1'b1, 1'b0);
        step(1'b1, 1'b1);
        hold(5, 1'b1, 1'b0);

        gesture(5, 0, 0, 1'b0, 1'b0);     // single
        gesture(4, 4, 4, 1'b1, 1'b0);     // double
        gesture(4, 8, 3, 1'b1, 1'b0);     // second press on timeout cycle
        gesture(40, 0, 0, 1'b0, 1'b0);    // long with three repeats
        gesture(20, 0, 0, 1'b0, 1'b0);    // release on long threshold
        gesture(3, 2, 45, 1'b1, 1'b0);    // long second press stays double
        gesture(21, 0, 0, 1'b0, 1'b0);    // just long, no repeat
        gesture(25, 0, 0, 1'b0, 1'b0);    // release on repeat cycle

        // Reset while waiting for the second press.
        step(1'b1, 1'b0);
        t = cyc;
        mark_busy(t + 1, t + 7);
        mark_held(t + 1, t + 5);
        hold(4, 1'b0, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        key_flag = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        hold(20, 1'b1, 1'b0);

        // Reset during a long hold, one cycle before a repeat would fire.
        step(1'b1, 1'b0);
        t = cyc;
        push(K_LONG, t + LONG_CYC + 1);
        push(K_REP, t + LONG_CYC + 1 + REPEAT_CYC);
        mark_busy(t + 1, t + 30);
        mark_held(t + 1, t + 30);
        hold(29, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        key_flag = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, 1'b1);
        hold(20, 1'b1, 1'b0);

        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 2);
            if (kind == 0)
                gesture($urandom_range(1, LONG_CYC), 0, 0, 1'b0, 1'b1);
            else if (kind == 1)
                gesture($urandom_range(1, LONG_CYC), $urandom_range(1, DBL_GAP_CYC),
                        $urandom_range(1, 50), 1'b1, 1'b1);
            else
                gesture($urandom_range(LONG_CYC + 1, LONG_CYC + 25), 0, 0, 1'b0, 1'b1);
        end

        hold(30, 1'b1, 1'b0);
        final_check = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #(MAXC * 10);
        $display("FAIL watchdog: simulation exceeded %0d cycles", MAXC);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/key_press_decoder.md
Name: key_press_decoder

Overview:
- Downstream stage of a key debounce filter. Consumes the filter's one-cycle change flag and its debounced level.
- Classifies each gesture as single click, double click or long press. Emits auto-repeat pulses while a long press is held.
- Its one-cycle event pulses feed the LED control logic in place of raw press flags.
- One instance per key.

Parameters:
- LONG_CYC, 50_000_000, hold cycles from press to long-press detection (1 s at 50 MHz); must be >= 2.
- DBL_GAP_CYC, 12_500_000, max release-to-second-press gap for a double click (250 ms); must be >= 2.
- REPEAT_CYC, 10_000_000, cycles between auto-repeat pulses after long detection (200 ms); must be >= 2.
- CNT_W, 26, internal counter width; must hold max(LONG_CYC, DBL_GAP_CYC, REPEAT_CYC).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- key_flag  in  1  one-cycle pulse when the debounced level changes.
- key_state  in  1  debounced level; 0 = pressed, 1 = released. Valid when key_flag = 1.
- single_pulse  out  1  one-cycle single-click event.
- double_pulse  out  1  one-cycle double-click event.
- long_pulse  out  1  one-cycle long-press detection event.
- repeat_pulse  out  1  one-cycle auto-repeat event during a long hold.
- key_held  out  1  high while the decoder tracks the key as pressed.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Events:
  - press = key_flag & ~key_state.
  - release = key_flag & key_state.
  - key_flag with a level matching the tracked level is ignored (spurious).
- Reset: all outputs 0, state IDLE, counter 0, at the first clk edge with rst = 1. Reset mid-gesture discards the gesture; no pulse is emitted for it.
- All outputs are registered. Each pulse is high for exactly one cycle. At most one pulse per cycle.
- Counter: cleared on every state entry, increments by 1 each cycle in PRESS1, WAIT2 and LONG.
- States:
  - IDLE:
    - press -> PRESS1.
    - release ignored.
  - PRESS1 (first press held):
    - release -> WAIT2.
    - Else if cnt == LONG_CYC-1 -> LONG, long_pulse.
    - Release and threshold in the same cycle: release wins, no long_pulse.
  - WAIT2 (released, waiting for second press):
    - press -> PRESS2.
    - Else if cnt == DBL_GAP_CYC-1 -> IDLE, single_pulse.
    - Press and timeout in the same cycle: press wins, giving a double click.
  - PRESS2 (second press held):
    - release -> IDLE, double_pulse.
    - No long detection in this state, regardless of hold length.
  - LONG:
    - When cnt == REPEAT_CYC-1: repeat_pulse, counter wraps to 0.
    - release -> IDLE with no further pulse. Release takes priority over a coincident repeat.
- Latency, with the triggering flag at cycle t:
  - long_pulse is high at cycle t+LONG_CYC+1.
  - single_pulse is high at release cycle t+DBL_GAP_CYC+1.
  - double_pulse is high at t+1 after the second release.
  - First repeat_pulse comes REPEAT_CYC cycles after long_pulse, then every REPEAT_CYC cycles.
- Status outputs:
  - key_held = 1 in PRESS1, PRESS2 and LONG.
  - Both key_held and busy are registered with the state.
- A gesture produces exactly one of single, double or long; repeats only follow long.
- Counter never exceeds its terminal value. No overflow is possible with a correctly sized CNT_W.

Test Plan:
1. Reset and idle: rst high for 3 cycles, then no key_flag for 100 cycles -> all outputs 0, busy 0 throughout. Release flag while IDLE -> no pulse, busy stays 0.
2. Single click (LONG_CYC=20, DBL_GAP_CYC=8, REPEAT_CYC=5): press at t0, release at t0+5 -> single_pulse exactly at release+9. No other pulse. busy falls with it.
3. Double click (same parameters):
   - press t0, release t0+4, press t0+8, release t0+12 -> double_pulse at t0+13, no single_pulse.
   - Repeat with the second press exactly at release+8 (timeout cycle) -> still double.
4. Long press with repeat (same parameters): press at t0, held 40 cycles -> long_pulse at t0+21, repeat_pulse at t0+26, +31, +36. Release -> no further pulses, no single.
5. Boundary at long threshold: release flag in the same cycle cnt == 19 -> no long_pulse; enters WAIT2, single_pulse 9 cycles later.
6. Reset mid-operation: assert rst while in WAIT2 and while in LONG -> next cycle all outputs 0 and busy 0. No single or repeat pulse is ever emitted for the aborted gesture.
